// File: rtl/uart_pkg.sv
// Shared UART definitions: FCR trigger encodings, receive error bit layout
// and default receive FIFO sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_14 = 2'b11
  } trig_lvl_e;

  localparam int ERR_W       = 3;
  localparam int ERR_PARITY  = 0;
  localparam int ERR_FRAMING = 1;
  localparam int ERR_BREAK   = 2;

  localparam int DEF_FIFO_DEPTH    = 16;
  localparam int DEF_TIMEOUT_CHARS = 4;

  // FCR[7:6] to number of queued characters that raises the data-available interrupt.
  function automatic logic [4:0] trig_decode(input trig_lvl_e t);
    case (t)
      TRIG_1:  return 5'd1;
      TRIG_4:  return 5'd4;
      TRIG_8:  return 5'd8;
      default: return 5'd14;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo_ctrl_if.sv
// Receive-path bundle between the serial receiver / register block (master)
// and the RX FIFO controller (slave).
interface uart_rx_fifo_ctrl_if
  import uart_pkg::*;
;
  logic             i_fifo_en;
  logic             i_rx_fifo_clr;
  logic [1:0]       i_trig_lvl;
  logic             i_rx_valid;
  logic [7:0]       i_rx_data;
  logic [ERR_W-1:0] i_rx_err;
  logic             i_char_tick;
  logic             i_rbr_rd;
  logic             i_lsr_rd;
  logic             o_rbr_valid;
  logic [7:0]       o_rbr_data;
  logic [ERR_W-1:0] o_rbr_err;
  logic [4:0]       o_rx_level;
  logic             o_dr;
  logic             o_oe;
  logic             o_fifo_err;
  logic             o_rda_int;
  logic             o_cto_int;

  modport master (
    output i_fifo_en, i_rx_fifo_clr, i_trig_lvl, i_rx_valid, i_rx_data, i_rx_err,
           i_char_tick, i_rbr_rd, i_lsr_rd,
    input  o_rbr_valid, o_rbr_data, o_rbr_err, o_rx_level, o_dr, o_oe,
           o_fifo_err, o_rda_int, o_cto_int
  );

  modport slave (
    input  i_fifo_en, i_rx_fifo_clr, i_trig_lvl, i_rx_valid, i_rx_data, i_rx_err,
           i_char_tick, i_rbr_rd, i_lsr_rd,
    output o_rbr_valid, o_rbr_data, o_rbr_err, o_rx_level, o_dr, o_oe,
           o_fifo_err, o_rda_int, o_cto_int
  );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// RX FIFO storage: register array with one write port and one registered
// read port. Addressing and flags belong to the controller.
module uart_rx_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 11,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data_p1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // ---- stage p0: write port
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // ---- stage p1: registered read, holds until the next read
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      rd_data_p1 <= '0;
    end else if (rd_en) begin
      rd_data_p1 <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// 16550 receive FIFO controller: pointers, occupancy, FCR enable/clear/trigger,
// LSR receive flags and the data-available / character-timeout interrupts.
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CHARS = DEF_TIMEOUT_CHARS
) (
  input  logic               i_sys_clk,
  input  logic               i_sys_rst,
  uart_rx_fifo_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = 5;
  localparam int TO_W  = $clog2(TIMEOUT_CHARS + 1);
  localparam int ENT_W = ERR_W + 8;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CHARS);

  // Character-time counter saturates at the timeout threshold.
  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v == TO_MAX) ? v : v + TO_W'(1);
  endfunction

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] err_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             fifo_en_q;
  logic             oe;
  logic             vld_p1;
  logic [ENT_W-1:0] rd_ent_p1;

  logic             clr;
  logic [LVL_W-1:0] depth_eff;
  logic [LVL_W-1:0] trig_eff;
  logic             full;
  logic             push_ok;
  logic             drop;
  logic             pop_ok;
  logic             err_inc;
  logic             err_dec;

  // ---- stage p0: request qualification against current state
  assign clr       = bus.i_rx_fifo_clr | (bus.i_fifo_en != fifo_en_q);
  assign depth_eff = bus.i_fifo_en ? DEPTH_L : LVL_W'(1);
  assign trig_eff  = bus.i_fifo_en ? trig_decode(trig_lvl_e'(bus.i_trig_lvl)) : LVL_W'(1);
  assign full      = (level >= depth_eff);
  assign push_ok   = ~clr & bus.i_rx_valid & ~full;
  assign drop      = ~clr & bus.i_rx_valid & full;
  assign pop_ok    = ~clr & bus.i_rbr_rd & (level != '0);
  assign err_inc   = push_ok & (|bus.i_rx_err);
  assign err_dec   = vld_p1 & (|rd_ent_p1[ENT_W-1 -: ERR_W]);

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      err_cnt   <= '0;
      to_cnt    <= '0;
      fifo_en_q <= 1'b0;
      oe        <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      fifo_en_q <= bus.i_fifo_en;
      vld_p1    <= pop_ok;

      if (drop) begin
        oe <= 1'b1;
      end else if (bus.i_lsr_rd) begin
        oe <= 1'b0;
      end

      if (clr) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level   <= '0;
        err_cnt <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
        level   <= level + LVL_W'(push_ok) - LVL_W'(pop_ok);
        err_cnt <= err_cnt + LVL_W'(err_inc) - LVL_W'(err_dec);
      end

      if (clr || push_ok || pop_ok || (level == '0)) begin
        to_cnt <= '0;
      end else if (bus.i_char_tick) begin
        to_cnt <= sat_inc(to_cnt);
      end
    end
  end

  uart_rx_fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W),
    .ADDR_W(PTR_W)
  ) u_mem (
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .wr_en     (push_ok),
    .wr_addr   (wr_ptr),
    .wr_data   ({bus.i_rx_err, bus.i_rx_data}),
    .rd_en     (pop_ok),
    .rd_addr   (rd_ptr),
    .rd_data_p1(rd_ent_p1)
  );

  // ---- stage p1: registered read result and flags decoded from state
  assign bus.o_rbr_valid = vld_p1;
  assign bus.o_rbr_data  = rd_ent_p1[7:0];
  assign bus.o_rbr_err   = rd_ent_p1[ENT_W-1 -: ERR_W];
  assign bus.o_rx_level  = level;
  assign bus.o_dr        = (level != '0);
  assign bus.o_oe        = oe;
  assign bus.o_fifo_err  = (err_cnt != '0);
  assign bus.o_rda_int   = (level >= trig_eff);
  assign bus.o_cto_int   = bus.i_fifo_en & (level != '0) & (to_cnt == TO_MAX);

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl: a table of per-cycle vectors with
// hand-computed outputs, followed by sequences for full/overrun, clear,
// mode switching and asynchronous reset during a read.
module tb_uart_rx_fifo_ctrl;
  import uart_pkg::*;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [2:0] e;
    logic       rd;
    logic       lsr;
    logic       clr;
    logic       tick;
    logic [4:0] lvl;
    logic       dr;
    logic       oe;
    logic       rda;
    logic       cto;
    logic       ferr;
    logic       rv;
    logic [7:0] rdat;
    logic [2:0] rerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  uart_rx_fifo_ctrl_if bus ();

  uart_rx_fifo_ctrl #(
    .FIFO_DEPTH   (16),
    .TIMEOUT_CHARS(4)
  ) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [2:0] e,
                              input logic rd, input logic lsr, input logic clr, input logic tick,
                              input logic [4:0] lvl, input logic dr, input logic oe,
                              input logic rda, input logic cto, input logic ferr,
                              input logic rv, input logic [7:0] rdat, input logic [2:0] rerr);
    vec_t r;
    r.v = v; r.d = d; r.e = e; r.rd = rd; r.lsr = lsr; r.clr = clr; r.tick = tick;
    r.lvl = lvl; r.dr = dr; r.oe = oe; r.rda = rda; r.cto = cto; r.ferr = ferr;
    r.rv = rv; r.rdat = rdat; r.rerr = rerr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive pulses, advance past the edge, then release pulses.
  task automatic drv(input logic v, input logic [7:0] d, input logic [2:0] e,
                     input logic rd, input logic lsr, input logic clr, input logic tick);
    bus.i_rx_valid    = v;
    bus.i_rx_data     = d;
    bus.i_rx_err      = e;
    bus.i_rbr_rd      = rd;
    bus.i_lsr_rd      = lsr;
    bus.i_rx_fifo_clr = clr;
    bus.i_char_tick   = tick;
    @(posedge clk);
    #1;
    bus.i_rx_valid    = 1'b0;
    bus.i_rbr_rd      = 1'b0;
    bus.i_lsr_rd      = 1'b0;
    bus.i_rx_fifo_clr = 1'b0;
    bus.i_char_tick   = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] e);
    drv(1'b1, d, e, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    drv(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drv(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.i_fifo_en     = 1'b1;
    bus.i_trig_lvl    = TRIG_4;
    bus.i_rx_fifo_clr = 1'b0;
    bus.i_rx_valid    = 1'b0;
    bus.i_rx_data     = 8'h00;
    bus.i_rx_err      = 3'b000;
    bus.i_char_tick   = 1'b0;
    bus.i_rbr_rd      = 1'b0;
    bus.i_lsr_rd      = 1'b0;

    //        v  d      e     rd lsr clr tk   lvl  dr oe rda cto fe rv rdat   rerr
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(1, 8'h41, 3'b000, 0, 0, 0, 0, 5'd1, 1, 0, 0, 0, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(1, 8'h42, 3'b000, 0, 0, 0, 0, 5'd2, 1, 0, 0, 0, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(1, 8'h43, 3'b000, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(1, 8'h44, 3'b000, 0, 0, 0, 0, 5'd4, 1, 0, 1, 0, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 0, 5'd4, 1, 0, 1, 0, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 1, 8'h41, 3'b000));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 5'd2, 1, 0, 0, 0, 0, 1, 8'h42, 3'b000));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 5'd1, 1, 0, 0, 0, 0, 1, 8'h43, 3'b000));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 8'h44, 3'b000));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 8'h44, 3'b000));
    tbl.push_back(mk(1, 8'hA0, 3'b010, 0, 0, 0, 0, 5'd1, 1, 0, 0, 0, 1, 0, 8'h44, 3'b000));
    tbl.push_back(mk(1, 8'hA1, 3'b000, 0, 0, 0, 0, 5'd2, 1, 0, 0, 0, 1, 0, 8'h44, 3'b000));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 5'd1, 1, 0, 0, 0, 1, 1, 8'hA0, 3'b010));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 0, 5'd1, 1, 0, 0, 0, 0, 0, 8'hA0, 3'b010));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 1, 5'd1, 1, 0, 0, 0, 0, 0, 8'hA0, 3'b010));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 1, 5'd1, 1, 0, 0, 0, 0, 0, 8'hA0, 3'b010));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 1, 5'd1, 1, 0, 0, 0, 0, 0, 8'hA0, 3'b010));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 1, 5'd1, 1, 0, 0, 1, 0, 0, 8'hA0, 3'b010));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 0, 5'd1, 1, 0, 0, 1, 0, 0, 8'hA0, 3'b010));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 8'hA1, 3'b000));
    tbl.push_back(mk(1, 8'h5A, 3'b000, 1, 0, 0, 0, 5'd1, 1, 0, 0, 0, 0, 0, 8'hA1, 3'b000));
    tbl.push_back(mk(1, 8'h5B, 3'b000, 1, 0, 0, 0, 5'd1, 1, 0, 0, 0, 0, 1, 8'h5A, 3'b000));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 8'h5B, 3'b000));
    tbl.push_back(mk(1, 8'hC0, 3'b000, 0, 0, 0, 0, 5'd1, 1, 0, 0, 0, 0, 0, 8'h5B, 3'b000));
    tbl.push_back(mk(1, 8'hC1, 3'b000, 0, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0, 0, 8'h5B, 3'b000));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 8'h5B, 3'b000));
    tbl.push_back(mk(1, 8'hE0, 3'b001, 0, 0, 0, 0, 5'd1, 1, 0, 0, 0, 1, 0, 8'h5B, 3'b000));
    tbl.push_back(mk(1, 8'hE1, 3'b100, 1, 0, 0, 0, 5'd1, 1, 0, 0, 0, 1, 1, 8'hE0, 3'b001));
    tbl.push_back(mk(1, 8'hE3, 3'b010, 1, 0, 0, 0, 5'd1, 1, 0, 0, 0, 1, 1, 8'hE1, 3'b100));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 1, 8'hE3, 3'b010));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 8'hE3, 3'b010));

    // Reset state, before any clock edge
    #12;
    chk("rst_level", 32'(bus.o_rx_level), 0);
    chk("rst_dr",    32'(bus.o_dr), 0);
    chk("rst_oe",    32'(bus.o_oe), 0);
    chk("rst_rda",   32'(bus.o_rda_int), 0);
    chk("rst_cto",   32'(bus.o_cto_int), 0);
    chk("rst_ferr",  32'(bus.o_fifo_err), 0);
    chk("rst_rv",    32'(bus.o_rbr_valid), 0);
    chk("rst_rdata", 32'(bus.o_rbr_data), 0);
    chk("rst_rerr",  32'(bus.o_rbr_err), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drv(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].rd, tbl[i].lsr, tbl[i].clr, tbl[i].tick);
      chk($sformatf("v%0d_level", i), 32'(bus.o_rx_level),  32'(tbl[i].lvl));
      chk($sformatf("v%0d_dr", i),    32'(bus.o_dr),        32'(tbl[i].dr));
      chk($sformatf("v%0d_oe", i),    32'(bus.o_oe),        32'(tbl[i].oe));
      chk($sformatf("v%0d_rda", i),   32'(bus.o_rda_int),   32'(tbl[i].rda));
      chk($sformatf("v%0d_cto", i),   32'(bus.o_cto_int),   32'(tbl[i].cto));
      chk($sformatf("v%0d_ferr", i),  32'(bus.o_fifo_err),  32'(tbl[i].ferr));
      chk($sformatf("v%0d_rv", i),    32'(bus.o_rbr_valid), 32'(tbl[i].rv));
      chk($sformatf("v%0d_rdata", i), 32'(bus.o_rbr_data),  32'(tbl[i].rdat));
      chk($sformatf("v%0d_rerr", i),  32'(bus.o_rbr_err),   32'(tbl[i].rerr));
    end

    // Fill to 16, overrun with 0x55, drain in order
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 3'b000);
    chk("full_level", 32'(bus.o_rx_level), 16);
    chk("full_rda",   32'(bus.o_rda_int), 1);
    chk("full_oe",    32'(bus.o_oe), 0);
    push(8'h55, 3'b000);
    chk("ovr_level", 32'(bus.o_rx_level), 16);
    chk("ovr_oe",    32'(bus.o_oe), 1);
    for (int i = 0; i < 16; i++) begin
      pop();
      chk($sformatf("drain%0d_rv", i),    32'(bus.o_rbr_valid), 1);
      chk($sformatf("drain%0d_data", i),  32'(bus.o_rbr_data), 32'(8'h10 + i));
      chk($sformatf("drain%0d_level", i), 32'(bus.o_rx_level), 32'(15 - i));
    end
    pop();
    chk("drain_empty_rv",   32'(bus.o_rbr_valid), 0);
    chk("drain_empty_data", 32'(bus.o_rbr_data), 32'h1F);
    drv(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lsr_clr_oe", 32'(bus.o_oe), 0);

    // Full with same-cycle push, pop and LSR read: pop wins room-wise, overrun set wins
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 3'b000);
    drv(1'b1, 8'h66, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fullrw_level", 32'(bus.o_rx_level), 15);
    chk("fullrw_oe",    32'(bus.o_oe), 1);
    chk("fullrw_rv",    32'(bus.o_rbr_valid), 1);
    chk("fullrw_data",  32'(bus.o_rbr_data), 32'h20);

    // Clear pulses keep o_oe
    drv(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr15_level", 32'(bus.o_rx_level), 0);
    chk("clr15_oe",    32'(bus.o_oe), 1);
    for (int i = 0; i < 7; i++) push(8'(8'h30 + i), 3'b000);
    chk("lvl7_level", 32'(bus.o_rx_level), 7);
    chk("lvl7_rda",   32'(bus.o_rda_int), 1);
    drv(1'b1, 8'h3F, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr7_level", 32'(bus.o_rx_level), 0);
    chk("clr7_oe",    32'(bus.o_oe), 1);
    chk("clr7_rda",   32'(bus.o_rda_int), 0);
    pop();
    chk("clr7_pop_rv", 32'(bus.o_rbr_valid), 0);
    drv(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr7_lsr_oe", 32'(bus.o_oe), 0);

    // FIFO enable 1->0 flushes; 16450 mode holds a single character
    for (int i = 0; i < 3; i++) push(8'(8'h40 + i), 3'b000);
    chk("pre_tog_level", 32'(bus.o_rx_level), 3);
    bus.i_fifo_en = 1'b0;
    idle();
    chk("tog_level", 32'(bus.o_rx_level), 0);
    push(8'h77, 3'b000);
    chk("m450_level", 32'(bus.o_rx_level), 1);
    chk("m450_rda",   32'(bus.o_rda_int), 1);
    chk("m450_oe0",   32'(bus.o_oe), 0);
    push(8'h78, 3'b000);
    chk("m450_ovr_level", 32'(bus.o_rx_level), 1);
    chk("m450_ovr_oe",    32'(bus.o_oe), 1);
    pop();
    chk("m450_rv",   32'(bus.o_rbr_valid), 1);
    chk("m450_data", 32'(bus.o_rbr_data), 32'h77);
    chk("m450_dr",   32'(bus.o_dr), 0);

    // Asynchronous reset while a read result is being presented
    push(8'h99, 3'b101);
    push(8'h9A, 3'b000);
    pop();
    chk("mid_rv",   32'(bus.o_rbr_valid), 1);
    chk("mid_data", 32'(bus.o_rbr_data), 32'h99);
    chk("mid_oe",   32'(bus.o_oe), 1);
    rst = 1'b1;
    #2;
    chk("arst_rv",    32'(bus.o_rbr_valid), 0);
    chk("arst_data",  32'(bus.o_rbr_data), 0);
    chk("arst_err",   32'(bus.o_rbr_err), 0);
    chk("arst_level", 32'(bus.o_rx_level), 0);
    chk("arst_oe",    32'(bus.o_oe), 0);
    chk("arst_dr",    32'(bus.o_dr), 0);
    chk("arst_ferr",  32'(bus.o_fifo_err), 0);
    @(negedge clk);
    rst = 1'b0;
    push(8'hAB, 3'b000);
    chk("post_rst_level", 32'(bus.o_rx_level), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
